// File: rtl/logit_streamer.sv
// logit_streamer: holds NUM_CLASSES scores and streams them to a classifier.
// Config macro LOGIT_SAT_EN: saturate written values instead of truncating.
module logit_streamer #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 32,
    parameter int TIMEOUT     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic signed [ACC_W-1:0]  wr_data,
    input  logic                     launch,
    input  logic                     hold,
    input  logic                     done_in,
    input  logic [3:0]               max_index_in,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     out_start,
    output logic                     busy,
    output logic [3:0]               pred,
    output logic                     pred_valid,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(NUM_CLASSES + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] score_q [NUM_CLASSES];
    logic signed [DATA_W-1:0] score_d [NUM_CLASSES];
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_start_q, out_start_d;
    logic                     busy_q, busy_d;
    logic [3:0]               pred_q, pred_d;
    logic                     pred_valid_q, pred_valid_d;
    logic                     timeout_err_q, timeout_err_d;
    logic signed [DATA_W-1:0] wr_conv;

`ifdef LOGIT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp the accumulator value into the signed score range.
    always_comb begin
        if (wr_data > SAT_MAX) begin
            wr_conv = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (wr_data < SAT_MIN) begin
            wr_conv = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            wr_conv = wr_data[DATA_W-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^wr_data[ACC_W-1:DATA_W];

    // Keep only the low score-width bits of the accumulator value.
    always_comb begin
        wr_conv = wr_data[DATA_W-1:0];
    end
`endif

    // Next-state logic: score writes, beat sequencing and WAIT timeout.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        score_d       = score_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        out_start_d   = out_start_q;
        pred_d        = pred_q;
        pred_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en && (int'(wr_addr) < NUM_CLASSES)) begin
                    score_d[wr_addr] = wr_conv;
                end
                if (launch) begin
                    state_d       = STREAM;
                    out_start_d   = 1'b1;
                    timeout_err_d = 1'b0;
                    cnt_d         = '0;
                    idx_d         = '0;
                    if (!hold) begin
                        out_valid_d = 1'b1;
                        out_data_d  = score_q[0];
                        idx_d       = IDX_W'(1);
                    end
                end
            end
            STREAM: begin
                if (idx_q == IDX_W'(NUM_CLASSES)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (!hold) begin
                    out_valid_d = 1'b1;
                    out_data_d  = score_q[idx_q];
                    idx_d       = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                // done_in beats a timeout landing on the same edge.
                if (done_in) begin
                    pred_d       = max_index_in;
                    pred_valid_d = 1'b1;
                    out_start_d  = 1'b0;
                    state_d      = IDLE;
                    idx_d        = '0;
                    cnt_d        = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    out_start_d   = 1'b0;
                    state_d       = IDLE;
                    idx_d         = '0;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_q[i] <= '0;
            end
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            pred_q        <= '0;
            pred_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            score_q       <= score_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_start_q   <= out_start_d;
            busy_q        <= busy_d;
            pred_q        <= pred_d;
            pred_valid_q  <= pred_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_start   = out_start_q;
    assign busy        = busy_q;
    assign pred        = pred_q;
    assign pred_valid  = pred_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_logit_streamer.sv
// tb_logit_streamer: randomized scoreboard bench for logit_streamer.
// Beats and predictions are queued at stimulus time and popped by a monitor.
module tb_logit_streamer;

    localparam int N = 10;
    localparam int T = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic signed [31:0] wr_data;
    logic               launch;
    logic               hold;
    logic               done_in;
    logic [3:0]         max_index_in;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_start;
    logic               busy;
    logic [3:0]         pred;
    logic               pred_valid;
    logic               timeout_err;

    always #5 clk = ~clk;

    logit_streamer dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .launch       (launch),
        .hold         (hold),
        .done_in      (done_in),
        .max_index_in (max_index_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_start    (out_start),
        .busy         (busy),
        .pred         (pred),
        .pred_valid   (pred_valid),
        .timeout_err  (timeout_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int launch_cyc = 0;
    int pv_cyc = -1;

    logic signed [15:0] beat_q [$];
    logic [3:0]         pred_q [$];
    logic signed [15:0] model [N];
    logic [3:0]         model_pred = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] conv(input int v);
`ifdef LOGIT_SAT_EN
        if (v > 32767) return 16'sh7FFF;
        if (v < -32768) return 16'sh8000;
`endif
        return 16'(v);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented beat / prediction must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
                else check("beat", int'(out_data), int'(beat_q.pop_front()));
            end
            if (pred_valid) begin
                pv_cyc = cyc;
                if (pred_q.size() == 0) check("unexpected_pred", 1, 0);
                else check("pred", int'(pred), int'(pred_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (addr < N) model[addr] = conv(data);
    endtask

    function automatic int rand_val();
        case ($urandom_range(0, 2))
            0: return int'($urandom_range(0, 400)) - 200;
            1: return int'($urandom_range(0, 131070)) - 65535;
            default: return int'($urandom);
        endcase
    endfunction

    function automatic logic pick_hold(input int mode, input int issued,
                                       input int hrun);
        if (mode == 1) return (issued == 5) && (hrun < 3);
        if (mode == 2) return $urandom_range(0, 3) == 0;
        return 1'b0;
    endfunction

    // Launch and stream all beats, leaving the DUT in WAIT.
    task automatic stream(input int mode, input bit wr_during,
                          output int holds);
        int issued;
        logic signed [15:0] prev;
        holds  = 0;
        pv_cyc = -1;
        for (int i = 0; i < N; i++) beat_q.push_back(model[i]);
        launch = 1'b1;
        hold   = pick_hold(mode, 0, 0);
        tick();
        launch     = 1'b0;
        launch_cyc = cyc;
        check("launch_start", int'(out_start), 1);
        check("launch_busy", int'(busy), 1);
        check("launch_tmo_clear", int'(timeout_err), 0);
        check("launch_valid", int'(out_valid), int'(!hold));
        issued = hold ? 0 : 1;
        holds  = hold ? 1 : 0;
        for (int k = 0; k < 200 && issued < N; k++) begin
            hold = pick_hold(mode, issued, holds);
            if (wr_during && issued == 2) begin
                wr_en   = 1'b1;
                wr_addr = 4'd3;
                wr_data = rand_val();
            end
            prev = out_data;
            tick();
            wr_en = 1'b0;
            if (hold) begin
                holds++;
                check("hold_valid", int'(out_valid), 0);
                check("hold_data", int'(out_data), int'(prev));
            end else begin
                issued++;
            end
            check("stream_start", int'(out_start), 1);
        end
        check("beats_issued", issued, N);
        hold = 1'b0;
        tick();
        check("wait_valid", int'(out_valid), 0);
        check("wait_busy", int'(busy), 1);
        check("wait_start", int'(out_start), 1);
        check("beats_left", beat_q.size(), 0);
    endtask

    task automatic finish_done(input int d, input int holds, input int idx);
        for (int i = 0; i < d; i++) begin
            tick();
            check("wait_hold_busy", int'(busy), 1);
        end
        done_in      = 1'b1;
        max_index_in = 4'(idx);
        model_pred   = 4'(idx);
        pred_q.push_back(4'(idx));
        tick();
        done_in = 1'b0;
        check("done_pv", int'(pred_valid), 1);
        check("done_start", int'(out_start), 0);
        check("done_busy", int'(busy), 0);
        check("done_tmo", int'(timeout_err), 0);
        tick();
        check("pv_pulse", int'(pred_valid), 0);
        check("latency", pv_cyc - launch_cyc, N + 1 + holds + d);
    endtask

    task automatic timeout_run();
        for (int i = 0; i < T; i++) begin
            launch = (i == 2);
            tick();
            launch = 1'b0;
            if (i < T - 1) begin
                check("tmo_early", int'(timeout_err), 0);
                check("tmo_busy", int'(busy), 1);
                check("tmo_novalid", int'(out_valid), 0);
            end
        end
        check("tmo_err", int'(timeout_err), 1);
        check("tmo_start", int'(out_start), 0);
        check("tmo_idle", int'(busy), 0);
        check("tmo_pred", int'(pred), int'(model_pred));
        check("tmo_pv", int'(pred_valid), 0);
    endtask

    initial begin
        int h;
        int init [N] = '{5, -3, 100, 7, 0, 0, 0, 0, 0, -1};
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        launch = 1'b0; hold = 1'b0; done_in = 1'b0; max_index_in = '0;
        for (int i = 0; i < N; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_start", int'(out_start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pv", int'(pred_valid), 0);
        check("rst_tmo", int'(timeout_err), 0);
        check("rst_pred", int'(pred), 0);
        check("rst_data", int'(out_data), 0);
        reset = 1'b0;
        tick();

        // Known scores, no hold, prompt classifier.
        for (int i = 0; i < N; i++) do_write(i, init[i]);
        stream(0, 1'b0, h);
        finish_done(0, h, 2);

        // Three-cycle stall after beat 4.
        for (int i = 0; i < N; i++) do_write(i, rand_val());
        stream(1, 1'b0, h);
        check("hold_count", h, 3);
        finish_done(int'($urandom_range(0, T - 2)), h, int'($urandom_range(0, 9)));

        // Timeout, launch ignored in WAIT, done ignored in IDLE.
        stream(2, 1'b0, h);
        timeout_run();
        tick();
        check("tmo_sticky", int'(timeout_err), 1);
        done_in = 1'b1;
        max_index_in = model_pred + 4'd1;
        tick();
        done_in = 1'b0;
        check("idle_done_pred", int'(pred), int'(model_pred));
        check("idle_done_busy", int'(busy), 0);
        check("idle_done_pv", int'(pred_valid), 0);
        stream(0, 1'b0, h);
        finish_done(T - 1, h, int'($urandom_range(0, 9)));

        // Conversion boundaries and an out-of-range address.
        do_write(0, 32'h0001_0000);
        do_write(1, 32'hFFFF_0000);
        do_write(2, 32767);
        do_write(3, -32768);
        do_write(4, 32768);
        do_write(5, -32769);
        do_write(12, 1234);
        stream(0, 1'b0, h);
        finish_done(1, h, int'($urandom_range(0, 9)));

        // Reset while beat 6 is on the output.
        for (int i = 0; i < N; i++) do_write(i, rand_val());
        for (int i = 0; i < N; i++) beat_q.push_back(model[i]);
        launch = 1'b1;
        tick();
        launch = 1'b0;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_start", int'(out_start), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_pred", int'(pred), 0);
        check("mid_rst_tmo", int'(timeout_err), 0);
        beat_q.delete();
        for (int i = 0; i < N; i++) model[i] = '0;
        model_pred = 4'd0;
        #3 reset = 1'b0;
        tick();
        stream(0, 1'b0, h);
        finish_done(0, h, int'($urandom_range(0, 9)));

        // Write during STREAM must not land.
        for (int i = 0; i < N; i++) do_write(i, rand_val());
        stream(2, 1'b1, h);
        finish_done(0, h, int'($urandom_range(0, 9)));
        stream(0, 1'b0, h);
        finish_done(0, h, int'($urandom_range(0, 9)));

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) do_write(int'($urandom_range(0, 15)), rand_val());
            stream(2, 1'b0, h);
            if ($urandom_range(0, 3) == 0) timeout_run();
            else finish_done(int'($urandom_range(0, T - 1)), h, int'($urandom_range(0, 15)));
            tick();
        end

        check("beat_q_empty", beat_q.size(), 0);
        check("pred_q_empty", pred_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
